// File: rtl/c2sif_arb.sv
// c2sif_arb -- round-robin arbiter that connects NREQ scenario requesters to a
// single shared driver channel. It serves one transaction at a time through a
// four-phase handshake on both sides, and it has a watchdog on the downstream
// handshake.
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   up_req  / up_ack        : per-requester request / acknowledge levels
//   up_id / up_fn / up_wdata: packed request fields, slice i = requester i
//   up_rdata / up_ret       : response returned to the granted requester
//   dn_req  / dn_ack        : shared driver channel handshake
//   dn_id / dn_fn / dn_wdata: latched fields of the granted request
//   dn_rdata / dn_ret       : driver response fields
//   gnt                     : one-hot index of the requester being served
//   tmo_err                 : sticky downstream timeout flag
module c2sif_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 8,
    parameter int FNW  = 8,
    parameter int TMO  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     up_req,
    output logic [NREQ-1:0]     up_ack,
    input  logic [NREQ*IDW-1:0] up_id,
    input  logic [NREQ*FNW-1:0] up_fn,
    input  logic [NREQ*DW-1:0]  up_wdata,
    output logic [DW-1:0]       up_rdata,
    output logic [DW-1:0]       up_ret,
    output logic                dn_req,
    input  logic                dn_ack,
    output logic [IDW-1:0]      dn_id,
    output logic [FNW-1:0]      dn_fn,
    output logic [DW-1:0]       dn_wdata,
    input  logic [DW-1:0]       dn_rdata,
    input  logic [DW-1:0]       dn_ret,
    output logic [NREQ-1:0]     gnt,
    output logic                tmo_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, DREQ, DREL, UACK} state_t;

    state_t             state_reg, state_next;
    logic [IW-1:0]      idx_reg, idx_next;
    logic [IW-1:0]      last_reg, last_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [NREQ-1:0]    up_ack_reg, up_ack_next;
    logic [NREQ-1:0]    gnt_reg, gnt_next;
    logic [DW-1:0]      up_rdata_reg, up_rdata_next;
    logic [DW-1:0]      up_ret_reg, up_ret_next;
    logic               dn_req_reg, dn_req_next;
    logic [IDW-1:0]     dn_id_reg, dn_id_next;
    logic [FNW-1:0]     dn_fn_reg, dn_fn_next;
    logic [DW-1:0]      dn_wdata_reg, dn_wdata_next;
    logic               tmo_err_reg, tmo_err_next;

    // Unpacked views of the packed request fields.
    logic [IDW-1:0] id_arr    [NREQ];
    logic [FNW-1:0] fn_arr    [NREQ];
    logic [DW-1:0]  wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign id_arr[gi]    = up_id[gi*IDW +: IDW];
            assign fn_arr[gi]    = up_fn[gi*FNW +: FNW];
            assign wdata_arr[gi] = up_wdata[gi*DW +: DW];
        end
    endgenerate

    // Round-robin pick: scan from last+1 upward, wrapping, so the requester
    // that was served last has the lowest priority.
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    int            cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_reg) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!pick_found && up_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        last_next     = last_reg;
        cnt_next      = cnt_reg;
        up_ack_next   = up_ack_reg;
        gnt_next      = gnt_reg;
        up_rdata_next = up_rdata_reg;
        up_ret_next   = up_ret_reg;
        dn_req_next   = dn_req_reg;
        dn_id_next    = dn_id_reg;
        dn_fn_next    = dn_fn_reg;
        dn_wdata_next = dn_wdata_reg;
        tmo_err_next  = tmo_err_reg;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    idx_next      = pick_idx;
                    gnt_next      = NREQ'(1) << pick_idx;
                    dn_id_next    = id_arr[pick_idx];
                    dn_fn_next    = fn_arr[pick_idx];
                    dn_wdata_next = wdata_arr[pick_idx];
                    dn_req_next   = 1'b1;
                    cnt_next      = '0;
                    state_next    = DREQ;
                end
            end
            DREQ: begin
                if (dn_ack) begin
                    up_rdata_next = dn_rdata;
                    up_ret_next   = dn_ret;
                    dn_req_next   = 1'b0;
                    cnt_next      = cnt_reg + 1'b1;
                    state_next    = DREL;
                end else if (cnt_reg == CW'(TMO - 1)) begin
                    dn_req_next   = 1'b0;
                    up_rdata_next = '0;
                    up_ret_next   = '1;
                    tmo_err_next  = 1'b1;
                    up_ack_next   = gnt_reg;
                    state_next    = UACK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DREL: begin
                // The watchdog keeps running here in case the driver never
                // releases its acknowledge.
                if (!dn_ack) begin
                    up_ack_next = gnt_reg;
                    state_next  = UACK;
                end else if (cnt_reg == CW'(TMO - 1)) begin
                    up_rdata_next = '0;
                    up_ret_next   = '1;
                    tmo_err_next  = 1'b1;
                    up_ack_next   = gnt_reg;
                    state_next    = UACK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            UACK: begin
                // A requester that already dropped its request leaves after
                // exactly one cycle of acknowledge.
                if (!up_req[idx_reg]) begin
                    up_ack_next = '0;
                    gnt_next    = '0;
                    last_next   = idx_reg;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            last_reg     <= IW'(NREQ - 1);
            cnt_reg      <= '0;
            up_ack_reg   <= '0;
            gnt_reg      <= '0;
            up_rdata_reg <= '0;
            up_ret_reg   <= '0;
            dn_req_reg   <= 1'b0;
            dn_id_reg    <= '0;
            dn_fn_reg    <= '0;
            dn_wdata_reg <= '0;
            tmo_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            last_reg     <= last_next;
            cnt_reg      <= cnt_next;
            up_ack_reg   <= up_ack_next;
            gnt_reg      <= gnt_next;
            up_rdata_reg <= up_rdata_next;
            up_ret_reg   <= up_ret_next;
            dn_req_reg   <= dn_req_next;
            dn_id_reg    <= dn_id_next;
            dn_fn_reg    <= dn_fn_next;
            dn_wdata_reg <= dn_wdata_next;
            tmo_err_reg  <= tmo_err_next;
        end
    end

    assign up_ack   = up_ack_reg;
    assign gnt      = gnt_reg;
    assign up_rdata = up_rdata_reg;
    assign up_ret   = up_ret_reg;
    assign dn_req   = dn_req_reg;
    assign dn_id    = dn_id_reg;
    assign dn_fn    = dn_fn_reg;
    assign dn_wdata = dn_wdata_reg;
    assign tmo_err  = tmo_err_reg;

endmodule

// File: tb/tb_c2sif_arb.sv
// Directed testbench for c2sif_arb: reset state, single write/read, contention
// order, early request drop, downstream timeout and reset mid-transaction.
module tb_c2sif_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 8;
    localparam int FNW  = 8;
    localparam int TMO  = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     up_req;
    logic [NREQ-1:0]     up_ack;
    logic [NREQ*IDW-1:0] up_id;
    logic [NREQ*FNW-1:0] up_fn;
    logic [NREQ*DW-1:0]  up_wdata;
    logic [DW-1:0]       up_rdata;
    logic [DW-1:0]       up_ret;
    logic                dn_req;
    logic                dn_ack;
    logic [IDW-1:0]      dn_id;
    logic [FNW-1:0]      dn_fn;
    logic [DW-1:0]       dn_wdata;
    logic [DW-1:0]       dn_rdata;
    logic [DW-1:0]       dn_ret;
    logic [NREQ-1:0]     gnt;
    logic                tmo_err;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    // Driver model: acknowledges one cycle after seeing dn_req and releases as
    // soon as dn_req falls.
    logic drv_en;
    logic ack_q;

    c2sif_arb #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .FNW(FNW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .up_ack(up_ack), .up_id(up_id), .up_fn(up_fn),
        .up_wdata(up_wdata), .up_rdata(up_rdata), .up_ret(up_ret),
        .dn_req(dn_req), .dn_ack(dn_ack), .dn_id(dn_id), .dn_fn(dn_fn),
        .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_ret(dn_ret),
        .gnt(gnt), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ack_q <= dn_req & drv_en;
    assign dn_ack = ack_q & dn_req;

    // While the channel is busy exactly one requester may be granted and no
    // upstream acknowledge may be active.
    always @(negedge clk) begin
        if (rst === 1'b1 && dn_req === 1'b1) begin
            if (!$onehot(gnt) || up_ack !== '0) viol++;
        end
    end

    task automatic set_req(input int i, input int id, input int fn, input int wd);
        up_id[i*IDW +: IDW]  = IDW'(id);
        up_fn[i*FNW +: FNW]  = FNW'(fn);
        up_wdata[i*DW +: DW] = DW'(wd);
        up_req[i]            = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(negedge clk);
            if (up_ack[i] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({dn_req, tmo_err} !== 2'b00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00", {dn_req, tmo_err});
        end
        total++;
        if (up_ack !== '0 || gnt !== '0) begin
            bad++; $display("FAIL reset_ack_gnt got=%b/%b exp=0/0", up_ack, gnt);
        end
        total++;
        if (dn_id !== '0 || dn_fn !== '0 || dn_wdata !== '0 || up_rdata !== '0 || up_ret !== '0) begin
            bad++; $display("FAIL reset_data got id=%h fn=%h wd=%h rd=%h ret=%h exp=0",
                            dn_id, dn_fn, dn_wdata, up_rdata, up_ret);
        end
        rst = 1'b1;
        @(negedge clk);
        $display("txn reset: released");
    endtask

    task automatic test_write;
        drv_en = 1'b1; dn_ret = 32'h0; dn_rdata = 32'h1234;
        set_req(0, 2, 0, 1);
        @(negedge clk);
        total++;
        if (dn_req !== 1'b1 || dn_id !== 8'd2 || dn_wdata !== 32'd1 || dn_fn !== 8'd0) begin
            bad++; $display("FAIL wr_fields got req=%b id=%h wd=%h fn=%h exp=1/02/1/00",
                            dn_req, dn_id, dn_wdata, dn_fn);
        end
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
        @(negedge clk);
        total++;
        if (up_ack !== 4'b0000) begin bad++; $display("FAIL wr_ack_k1 got=%b exp=0000", up_ack); end
        @(negedge clk);
        total++;
        if (dn_req !== 1'b0 || up_ack !== 4'b0000) begin
            bad++; $display("FAIL wr_k2 got req=%b ack=%b exp=0/0000", dn_req, up_ack);
        end
        @(negedge clk);
        total++;
        if (up_ack !== 4'b0001 || up_ret !== 32'h0) begin
            bad++; $display("FAIL wr_ack_k3 got ack=%b ret=%h exp=0001/0", up_ack, up_ret);
        end
        up_req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (up_ack !== '0 || gnt !== '0) begin
            bad++; $display("FAIL wr_release got ack=%b gnt=%b exp=0/0", up_ack, gnt);
        end
        $display("txn write: req0 id=2 wd=1 ret=%h", up_ret);
    endtask

    task automatic test_read;
        bit ok;
        dn_rdata = 32'd1; dn_ret = 32'h0;
        set_req(1, 5, 1, 0);
        wait_ack(1, 20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rd_ack_timeout got=0 exp=1");
        end else begin
            total++;
            if (up_rdata !== 32'd1 || gnt !== 4'b0010 || dn_fn !== 8'd1) begin
                bad++; $display("FAIL rd_data got rd=%h gnt=%b fn=%h exp=1/0010/01",
                                up_rdata, gnt, dn_fn);
            end
        end
        up_req[1] = 1'b0;
        @(negedge clk);
        $display("txn read: req1 rdata=%h", up_rdata);
    endtask

    task automatic test_contention;
        bit ok;
        logic [NREQ-1:0] exp_gnt;
        // Restart from reset so requester 0 has top priority.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        viol = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + i, 0, 100 + i);
        for (int t = 0; t < NREQ; t++) begin
            exp_gnt = NREQ'(1) << t;
            dn_rdata = 32'h0;
            dn_ret   = 32'h0;
            wait_ack(t, 20, ok);
            total++;
            if (!ok || gnt !== exp_gnt || dn_id !== 8'(8'h10 + t) || dn_wdata !== 32'(100 + t)) begin
                bad++; $display("FAIL cont_order%0d got ok=%0d gnt=%b id=%h wd=%0d exp gnt=%b id=%h",
                                t, ok, gnt, dn_id, dn_wdata, exp_gnt, 8'(8'h10 + t));
            end
            $display("txn contention: slot=%0d gnt=%b id=%h", t, gnt, dn_id);
            up_req[t] = 1'b0;
            @(negedge clk);
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL cont_overlap got=%0d exp=0", viol); end
    endtask

    task automatic test_early_drop;
        set_req(2, 7, 0, 9);
        @(negedge clk);
        up_req[2] = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (up_ack !== 4'b0100) begin bad++; $display("FAIL drop_ack got=%b exp=0100", up_ack); end
        @(negedge clk);
        total++;
        if (up_ack !== '0 || gnt !== '0) begin
            bad++; $display("FAIL drop_idle got ack=%b gnt=%b exp=0/0", up_ack, gnt);
        end
        $display("txn early_drop: req2 done");
    endtask

    task automatic test_timeout;
        int n;
        bit done;
        drv_en = 1'b0;
        dn_rdata = 32'h55; dn_ret = 32'h66;
        set_req(0, 3, 1, 0);
        n = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (dn_req === 1'b1) n++;
            else if (n > 0) done = 1'b1;
        end
        total++;
        if (n !== TMO) begin bad++; $display("FAIL tmo_len got=%0d exp=%0d", n, TMO); end
        total++;
        if (up_ret !== 32'hFFFFFFFF || up_rdata !== 32'h0 || tmo_err !== 1'b1 || up_ack !== 4'b0001) begin
            bad++; $display("FAIL tmo_resp got ret=%h rd=%h err=%b ack=%b exp=ffffffff/0/1/0001",
                            up_ret, up_rdata, tmo_err, up_ack);
        end
        up_req[0] = 1'b0;
        drv_en = 1'b1;
        repeat (2) @(negedge clk);
        dn_ret = 32'h0;
        set_req(3, 4, 0, 0);
        repeat (6) @(negedge clk);
        up_req[3] = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", tmo_err); end
        $display("txn timeout: cycles=%0d ret=%h", n, up_ret);
    endtask

    task automatic test_reset_mid;
        bit ok;
        drv_en = 1'b0;
        set_req(1, 9, 0, 0);
        @(negedge clk);
        total++;
        if (dn_req !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", dn_req); end
        rst = 1'b0;
        #1;
        total++;
        if (dn_req !== 1'b0 || up_ack !== '0 || gnt !== '0 || tmo_err !== 1'b0 ||
            dn_id !== '0 || up_ret !== '0) begin
            bad++; $display("FAIL rmid_clear got req=%b ack=%b gnt=%b err=%b id=%h ret=%h exp=0",
                            dn_req, up_ack, gnt, tmo_err, dn_id, up_ret);
        end
        up_req[1] = 1'b0;
        drv_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dn_rdata = 32'hA5; dn_ret = 32'h0;
        set_req(2, 6, 1, 0);
        wait_ack(2, 20, ok);
        total++;
        if (!ok || gnt !== 4'b0100 || up_rdata !== 32'hA5) begin
            bad++; $display("FAIL rmid_next got ok=%0d gnt=%b rd=%h exp=1/0100/a5", ok, gnt, up_rdata);
        end
        up_req[2] = 1'b0;
        @(negedge clk);
        $display("txn reset_mid: req2 served after reset");
    endtask

    initial begin
        rst = 1'b0; up_req = '0; up_id = '0; up_fn = '0; up_wdata = '0;
        dn_rdata = '0; dn_ret = '0; drv_en = 1'b0;
        test_reset;
        test_write;
        test_read;
        test_contention;
        test_early_drop;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c2sif_arb.md
C2SIF_ARB -- requirements
Module: c2sif_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of scenario requester ports (2..8).
REQ-002 SHALL have parameter DW, default 32, width of the data and return fields.
REQ-003 SHALL have parameter IDW, default 8, width of the driver id field.
REQ-004 SHALL have parameter FNW, default 8, width of the function code field.
REQ-005 SHALL have parameter TMO, default 255, limit in cycles for the downstream handshake.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port up_req, input, NREQ, per-requester request level.
REQ-009 SHALL have port up_ack, output, NREQ, per-requester acknowledge level.
REQ-010 SHALL have port up_id, input, NREQ*IDW, packed target id; slice i belongs to requester i.
REQ-011 SHALL have port up_fn, input, NREQ*FNW, packed function code (0 = write, 1 = read).
REQ-012 SHALL have port up_wdata, input, NREQ*DW, packed write data.
REQ-013 SHALL have port up_rdata, output, DW, read data returned to the granted requester.
REQ-014 SHALL have port up_ret, output, DW, return code returned to the granted requester.
REQ-015 SHALL have port dn_req, output, 1, request to the shared driver channel.
REQ-016 SHALL have port dn_ack, input, 1, acknowledge from the addressed driver.
REQ-017 SHALL have ports dn_id (IDW), dn_fn (FNW) and dn_wdata (DW), outputs, the latched fields of the granted request.
REQ-018 SHALL have ports dn_rdata (DW) and dn_ret (DW), inputs, the driver response fields.
REQ-019 SHALL have port gnt, output, NREQ, one-hot index of the requester currently being served (zero in IDLE).
REQ-020 SHALL have port tmo_err, output, 1, sticky flag for a downstream timeout.

Function
REQ-021 SHALL implement FSM states IDLE, DREQ, DREL and UACK; all outputs are registered.
REQ-022 IDLE: when any up_req bit is high at an edge, SHALL grant, round-robin, the first requester starting at index last+1 mod NREQ, latch its id/fn/wdata into dn_id/dn_fn/dn_wdata, set gnt, and go to DREQ; dn_req is 1 from that edge.
REQ-023 DREQ: when dn_ack=1 SHALL capture dn_rdata into up_rdata and dn_ret into up_ret, clear dn_req, and go to DREL.
REQ-024 DREL: when dn_ack=0 SHALL set up_ack[g]=1 and go to UACK.
REQ-025 UACK: when up_req[g]=0 SHALL clear up_ack[g] and gnt, set last=g, and go to IDLE.
REQ-026 Total latency with an immediately responding driver: up_req seen at edge k gives up_ack high at edge k+3.
REQ-027 SHALL serve at most one transaction at a time; dn_req is never 1 outside DREQ.
REQ-028 Requests that arrive or change during service SHALL be ignored until IDLE; the latched fields stay stable while dn_req=1.
REQ-029 SHALL run a cycle counter that is cleared on entry to DREQ and counts in DREQ and DREL.
REQ-030 On reaching TMO, SHALL set dn_req=0, up_rdata=0, up_ret=all-ones and tmo_err=1, then go to UACK.
REQ-031 tmo_err SHALL be cleared only by reset.
REQ-032 If up_req[g] falls before up_ack in DREQ/DREL, SHALL still complete the downstream handshake, then pass through UACK for one cycle with up_ack[g]=1 and return to IDLE.
REQ-033 After any reset, the round-robin pointer SHALL start so that requester 0 has the highest priority (last=NREQ-1).

Reset
REQ-034 rst=0 SHALL immediately force IDLE, with dn_req=0, up_ack=0, gnt=0, dn_id/dn_fn/dn_wdata=0, up_rdata=0, up_ret=0, tmo_err=0, counter=0 and last=NREQ-1.
REQ-035 Reset in the middle of a transaction SHALL abandon it without completing any handshake; on release, the FSM starts in IDLE.

Verification
REQ-036 Single write: up_req[0]=1, id=2, fn=0, wdata=1, driver acks after 1 cycle -> dn_id=2, dn_wdata=1, up_ack[0] rises, up_ret=0.
REQ-037 Single read: requester 1 with fn=1, driver returns dn_rdata=1 -> up_rdata=1 when up_ack[1]=1.
REQ-038 Contention: up_req=4'b1111 held through four transactions -> grant order 0,1,2,3, with no overlap of dn_req.
REQ-039 Timeout: dn_ack held at 0 -> dn_req drops after TMO=255 cycles, up_ret=32'hFFFFFFFF, tmo_err=1 until reset.
REQ-040 Reset with dn_req=1 in DREQ -> all outputs 0 at once; next up_req[2] alone is served normally.
